// File: rtl/soc_dbus_bridge.sv
// Data-bus bridge: RAM pass-through plus an I/O page holding an output register,
// a UART TX FIFO / RX holding byte and a free-running cycle counter.
module soc_dbus_bridge #(
    parameter int unsigned IO_AW     = 6,
    parameter int unsigned TXD_DEPTH = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCPU_CE,
    input  logic        iCPU_RD,
    input  logic        iCPU_WR,
    input  logic [31:0] iCPU_ADDR,
    input  logic [31:0] iCPU_DATA,
    output logic [31:0] oCPU_DATA,
    output logic        oRAM_CE,
    output logic        oRAM_RD,
    output logic        oRAM_WR,
    output logic [31:0] oRAM_ADDR,
    output logic [31:0] oRAM_DATA,
    input  logic [31:0] iRAM_DATA,
    output logic [31:0] oREG32,
    output logic [7:0]  oTX_DATA,
    output logic        oTX_VALID,
    input  logic        iTX_READY,
    input  logic [7:0]  iRX_DATA,
    input  logic        iRX_VALID,
    output logic        oRX_READY
);

    localparam int unsigned PTR_W = $clog2(TXD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [IO_AW-1:0] OFF_REG32  = IO_AW'(0);
    localparam logic [IO_AW-1:0] OFF_TX     = IO_AW'(1);
    localparam logic [IO_AW-1:0] OFF_STATUS = IO_AW'(2);
    localparam logic [IO_AW-1:0] OFF_RX     = IO_AW'(3);
    localparam logic [IO_AW-1:0] OFF_CYCLE  = IO_AW'(4);

    logic [IO_AW-1:0] io_off;
    logic             io_rd;
    logic             io_wr;
    logic [31:0]      io_rdata_c;
    logic             sel_io_q;
    logic [31:0]      io_rdata_q;
    logic [31:0]      cycle;

    logic [7:0]       tx_mem [TXD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_ovf;
    logic             push_req;
    logic             push_ok;
    logic             pop;

    logic [7:0]       rx_byte;
    logic             rx_full;
    logic             rx_rd;
    logic             rx_load;

    // RAM side is pure strobe gating on the page bit
    assign oRAM_CE   = iCPU_CE & ~iCPU_ADDR[31];
    assign oRAM_RD   = iCPU_RD & ~iCPU_ADDR[31];
    assign oRAM_WR   = iCPU_WR & ~iCPU_ADDR[31];
    assign oRAM_ADDR = iCPU_ADDR;
    assign oRAM_DATA = iCPU_DATA;

    assign io_off = iCPU_ADDR[IO_AW+1:2];
    assign io_rd  = iCPU_ADDR[31] & iCPU_CE & iCPU_RD;
    assign io_wr  = iCPU_ADDR[31] & iCPU_CE & iCPU_WR;

    assign tx_full   = (tx_count == CNT_W'(TXD_DEPTH));
    assign tx_empty  = (tx_count == '0);
    assign oTX_VALID = ~tx_empty;
    assign oTX_DATA  = tx_empty ? 8'h00 : tx_mem[rd_ptr];
    assign pop       = oTX_VALID & iTX_READY;
    assign push_req  = io_wr & (io_off == OFF_TX);
    assign push_ok   = push_req & (~tx_full | pop);

    // A read that coincides with a new byte lets the new byte in and keeps rx_full set
    assign rx_rd     = io_rd & (io_off == OFF_RX);
    assign rx_load   = iRX_VALID & (~rx_full | rx_rd);
    assign oRX_READY = ~rx_full;

    assign oCPU_DATA = sel_io_q ? io_rdata_q : iRAM_DATA;

    // I/O read decode, always from pre-write state
    always_comb begin
        io_rdata_c = '0;
        case (io_off)
            OFF_REG32:  io_rdata_c = oREG32;
            OFF_STATUS: io_rdata_c = {28'b0, tx_ovf, rx_full, tx_empty, tx_full};
            OFF_RX:     io_rdata_c = {24'b0, rx_byte};
            OFF_CYCLE:  io_rdata_c = cycle;
            default:    io_rdata_c = '0;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sel_io_q   <= 1'b0;
            io_rdata_q <= '0;
            oREG32     <= '0;
            cycle      <= '0;
        end else begin
            sel_io_q <= io_rd;
            if (io_rd) begin
                io_rdata_q <= io_rdata_c;
            end
            if (io_wr && (io_off == OFF_REG32)) begin
                oREG32 <= iCPU_DATA;
            end
            cycle <= cycle + 32'd1;
        end
    end

    // TX FIFO and sticky overflow flag
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
            tx_ovf   <= 1'b0;
            for (int unsigned i = 0; i < TXD_DEPTH; i++) begin
                tx_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                tx_mem[wr_ptr] <= iCPU_DATA[7:0];
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
            if (io_wr && (io_off == OFF_STATUS)) begin
                tx_ovf <= 1'b0;
            end else if (push_req && !push_ok) begin
                tx_ovf <= 1'b1;
            end
        end
    end

    // RX holding register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rx_byte <= '0;
            rx_full <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_byte <= iRX_DATA;
                rx_full <= 1'b1;
            end else if (rx_rd) begin
                rx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_soc_dbus_bridge.sv
// Self-checking bench for soc_dbus_bridge: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_soc_dbus_bridge;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] cpu_rdata;
    logic        ram_ce, ram_rd, ram_wr;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] reg32;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int n_checks = 0;
    int n_errors = 0;

    soc_dbus_bridge #(.IO_AW(6), .TXD_DEPTH(DEPTH)) dut (
        .iCLK(clk), .iRST(rst),
        .iCPU_CE(ce), .iCPU_RD(rd), .iCPU_WR(wr),
        .iCPU_ADDR(addr), .iCPU_DATA(wdata), .oCPU_DATA(cpu_rdata),
        .oRAM_CE(ram_ce), .oRAM_RD(ram_rd), .oRAM_WR(ram_wr),
        .oRAM_ADDR(ram_addr), .oRAM_DATA(ram_wdata), .iRAM_DATA(ram_rdata),
        .oREG32(reg32), .oTX_DATA(tx_data), .oTX_VALID(tx_valid), .iTX_READY(tx_ready),
        .iRX_DATA(rx_data), .iRX_VALID(rx_valid), .oRX_READY(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Small synchronous RAM behind the bridge
    logic [31:0] ram [16];
    initial for (int i = 0; i < 16; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (ram_ce && ram_wr) ram[ram_addr[5:2]] <= ram_wdata;
        if (ram_ce && ram_rd) ram_rdata <= ram[ram_addr[5:2]];
        else                  ram_rdata <= $urandom;
    end

    // Reference model state (value after the most recent clock edge)
    logic [31:0] m_reg32, m_cycle, m_rdata, m_rv, m_status;
    logic        m_sel_io, m_ovf, m_rx_full, m_pop, m_iord, m_iowr;
    logic [7:0]  m_rx_byte;
    logic [7:0]  m_q [$];
    int          m_off, m_sz;
    logic [7:0]  emitted [$];

    always @(negedge clk) begin
        if (rst) begin
            m_reg32 = '0; m_cycle = '0; m_rdata = '0; m_sel_io = 1'b0;
            m_ovf = 1'b0; m_rx_full = 1'b0; m_rx_byte = '0; m_q.delete();
            check("rst_tx_valid", 32'(tx_valid), 32'd0);
            check("rst_tx_data", 32'(tx_data), 32'd0);
            check("rst_rx_ready", 32'(rx_ready), 32'd1);
            check("rst_reg32", reg32, 32'd0);
            check("rst_cpu_data", cpu_rdata, ram_rdata);
        end else begin
            m_sz = m_q.size();
            check("reg32", reg32, m_reg32);
            check("tx_valid", 32'(tx_valid), 32'(m_sz != 0));
            check("tx_data", 32'(tx_data), (m_sz != 0) ? 32'(m_q[0]) : 32'd0);
            check("rx_ready", 32'(rx_ready), 32'(!m_rx_full));
            check("cpu_data", cpu_rdata, m_sel_io ? m_rdata : ram_rdata);
            check("ram_ce", 32'(ram_ce), 32'(ce && !addr[31]));
            check("ram_rd", 32'(ram_rd), 32'(rd && !addr[31]));
            check("ram_wr", 32'(ram_wr), 32'(wr && !addr[31]));
            check("ram_addr", ram_addr, addr);
            check("ram_data", ram_wdata, wdata);
            if (tx_valid && tx_ready) emitted.push_back(tx_data);

            // Advance the model over the coming edge
            m_off  = int'((addr >> 2) & 32'h3F);
            m_iord = addr[31] && ce && rd;
            m_iowr = addr[31] && ce && wr;
            m_status = (32'(m_ovf) << 3) | (32'(m_rx_full) << 2) |
                       (32'(m_sz == 0) << 1) | 32'(m_sz == DEPTH);
            case (m_off)
                0: m_rv = m_reg32;
                2: m_rv = m_status;
                3: m_rv = 32'(m_rx_byte);
                4: m_rv = m_cycle;
                default: m_rv = '0;
            endcase
            m_sel_io = m_iord;
            if (m_iord) m_rdata = m_rv;
            m_pop = (m_sz != 0) && tx_ready;
            if (m_pop) void'(m_q.pop_front());
            if (m_iowr) begin
                case (m_off)
                    0: m_reg32 = wdata;
                    1: if (m_sz < DEPTH || m_pop) m_q.push_back(wdata[7:0]); else m_ovf = 1'b1;
                    2: m_ovf = 1'b0;
                    default: ;
                endcase
            end
            if (rx_valid && (!m_rx_full || (m_iord && m_off == 3))) begin
                m_rx_byte = rx_data;
                m_rx_full = 1'b1;
            end else if (m_iord && m_off == 3) begin
                m_rx_full = 1'b0;
            end
            m_cycle = m_cycle + 32'd1;
        end
    end

    // One bus cycle: inputs applied just after a rising edge, held until the next one
    task automatic drive(input logic c, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        ce = c; rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_bus(input logic [31:0] a, output logic [31:0] q);
        drive(1'b1, 1'b1, 1'b0, a, 32'h0);
        q = cpu_rdata;
    endtask

    logic [31:0] v0, v1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, n_errors %0d", n_errors);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("init_reg32", reg32, 32'h0);
        check("init_tx_valid", 32'(tx_valid), 32'h0);
        rst = 1'b0;
        idle(2);

        // Cycle counter and REG32
        rd_bus(32'h8000_0010, v0);
        idle(4);
        rd_bus(32'h8000_0010, v1);
        check("cycle_delta", v1 - v0, 32'd5);
        io_write(32'h8000_0000, 32'hDEAD_BEEF);
        check("reg32_write", reg32, 32'hDEAD_BEEF);
        rd_bus(32'h8000_0000, v0);
        check("reg32_readback", v0, 32'hDEAD_BEEF);

        // TX overflow and drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) io_write(32'h8000_0004, 32'(8'h41 + i));
        rd_bus(32'h8000_0008, v0);
        check("status_full_ovf", v0, 32'h9);
        emitted.delete();
        tx_ready = 1'b1;
        idle(6);
        check("tx_drain_count", 32'(emitted.size()), 32'd4);
        for (int i = 0; i < emitted.size() && i < 4; i++)
            check("tx_drain_byte", 32'(emitted[i]), 32'(8'h41 + i));
        check("tx_valid_drained", 32'(tx_valid), 32'h0);
        rd_bus(32'h8000_0008, v0);
        check("status_empty_ovf", v0, 32'hA);
        io_write(32'h8000_0008, 32'h0);
        rd_bus(32'h8000_0008, v0);
        check("status_ovf_clear", v0, 32'h2);

        // Push into a full FIFO while it pops
        tx_ready = 1'b0;
        emitted.delete();
        for (int i = 0; i < 4; i++) io_write(32'h8000_0004, 32'(8'h50 + i));
        tx_ready = 1'b1;
        io_write(32'h8000_0004, 32'h55);
        idle(6);
        check("tx_fullpop_count", 32'(emitted.size()), 32'd5);
        if (emitted.size() == 5) check("tx_fifth_byte", 32'(emitted[4]), 32'h55);
        rd_bus(32'h8000_0008, v0);
        check("status_no_ovf", v0, 32'h2);

        // RX holding register
        rx_valid = 1'b1; rx_data = 8'h5A;
        idle(1);
        rx_valid = 1'b0;
        check("rx_ready_full", 32'(rx_ready), 32'h0);
        rd_bus(32'h8000_0008, v0);
        check("status_rx_full", v0, 32'h6);
        rx_valid = 1'b1; rx_data = 8'h33;
        idle(1);
        rx_valid = 1'b0;
        rd_bus(32'h8000_000C, v0);
        check("rx_first_byte", v0, 32'h5A);
        check("rx_ready_after_read", 32'(rx_ready), 32'h1);
        rx_valid = 1'b1; rx_data = 8'h77;
        idle(1);
        rx_data = 8'h33;
        rd_bus(32'h8000_000C, v0);
        rx_valid = 1'b0;
        check("rx_read_old", v0, 32'h77);
        check("rx_still_full", 32'(rx_ready), 32'h0);
        rd_bus(32'h8000_000C, v0);
        check("rx_new_byte", v0, 32'h33);

        // RAM pass-through and read-return ordering
        ce = 1'b1; rd = 1'b0; wr = 1'b1; addr = 32'h0000_0100; wdata = 32'h1234_5678;
        #2;
        check("ram_wr_pass", 32'(ram_wr), 32'h1);
        check("ram_addr_pass", ram_addr, 32'h0000_0100);
        check("ram_data_pass", ram_wdata, 32'h1234_5678);
        @(posedge clk); #1;
        ce = 1'b1; rd = 1'b0; wr = 1'b1; addr = 32'h8000_0040; wdata = 32'h0;
        #2;
        check("io_wr_ram_ce", 32'(ram_ce), 32'h0);
        @(posedge clk); #1;
        rd_bus(32'h0000_0100, v0);
        check("ram_read", v0, 32'h1234_5678);
        rd_bus(32'h8000_0000, v0);
        check("io_after_ram", v0, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tx_ready = ($urandom % 3) != 0;
            rx_valid = ($urandom % 4) == 0;
            rx_data  = 8'($urandom);
            if ($urandom % 2)
                v0 = 32'h8000_0000 | ($urandom & 32'h7FFF_FF03) | (32'($urandom_range(0, 7)) << 2);
            else
                v0 = $urandom & 32'h7FFF_FFFF;
            drive(($urandom % 8) != 0, 1'($urandom), 1'($urandom), v0, $urandom);
        end

        // Reset in the middle of activity
        tx_ready = 1'b0; rx_valid = 1'b0;
        io_write(32'h8000_0000, 32'hCAFE_0001);
        for (int i = 0; i < 3; i++) io_write(32'h8000_0004, 32'(8'h60 + i));
        rx_valid = 1'b1; rx_data = 8'h99;
        idle(1);
        rx_valid = 1'b0;
        check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
        check("pre_rst_rx_ready", 32'(rx_ready), 32'h0);
        rst = 1'b1;
        #1;
        check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("async_rst_rx_ready", 32'(rx_ready), 32'h1);
        check("async_rst_reg32", reg32, 32'h0);
        idle(2);
        rst = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
